gate_selftest: RTL and testbench

GATE_SELFTEST -- requirements
Module: gate_selftest

---
 rtl/gate_selftest.sv | 195 +++++++++++++++++++
 tb/tb_gate_selftest.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_selftest.sv
// gate_selftest: built-in self test for up to eight 2-input gate lanes.
// The block steps a shared stimulus pair {a,b} through 00, 01, 10, 11.
// Each vector is held for SETTLE+1 cycles. On the last cycle of each
// vector it compares every lane against its expected truth-table bit and
// accumulates the mismatches.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start, abort   begin a run (ignored unless idle) / cancel a run
//   expected       per-lane truth tables; bit g*4+{a,b} is lane g's required output
//   gate_out       observed lane outputs
//   a, b           shared stimulus driven to every lane
//   busy           run in progress
//   done, pass     last run finished / finished with no mismatches
//   err_count      mismatching (lane, vector) samples in the last run
//   fail_mask      bit g*4+v set when lane g mismatched on vector v
module gate_selftest #(
  parameter int N_GATES = 5,
  parameter int SETTLE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*N_GATES-1:0]   expected,
  input  logic [N_GATES-1:0]     gate_out,
  output logic                   a,
  output logic                   b,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [5:0]             err_count,
  output logic [4*N_GATES-1:0]   fail_mask
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [5:0]             err_q, err_d;
  logic [4*N_GATES-1:0]   fail_q, fail_d;

  logic                   sample_s;
  logic [N_GATES-1:0]     miss_s;
  logic [5:0]             miss_cnt_s;
  logic [6:0]             err_sum_s;
  logic [5:0]             err_sat_s;

  // Count the set bits of a lane-mismatch vector.
  function automatic logic [5:0] popcount(input logic [N_GATES-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < N_GATES; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort beats both start and the final sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (sample_s && (vec_q == 2'd3)) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The stimulus is forced to 00 outside a run.
  always_comb begin
    busy = (state_q == RUN);
    if (state_q == RUN) begin
      a = vec_q[1];
      b = vec_q[0];
    end else begin
      a = 1'b0;
      b = 1'b0;
    end
  end

  // Per-lane comparison against the truth-table bit for the current vector.
  always_comb begin
    miss_s = '0;
    for (int g = 0; g < N_GATES; g++) begin
      miss_s[g] = gate_out[g] ^ expected[g*4 + int'(vec_q)];
    end
  end

  assign sample_s   = (state_q == RUN) && (wcnt_q == SETTLE_W);
  assign miss_cnt_s = popcount(miss_s);
  assign err_sum_s  = {1'b0, err_q} + {1'b0, miss_cnt_s};
  // Saturate rather than wrap. This cannot trigger for N_GATES <= 8.
  assign err_sat_s  = err_sum_s[6] ? 6'h3F : err_sum_s[5:0];

  // Datapath next-state: vector/wait sequencing and result accumulation.
  always_comb begin
    vec_d  = vec_q;
    wcnt_d = wcnt_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    fail_d = fail_q;
    if (abort) begin
      // Partial err_count/fail_mask stay visible after an abort.
      vec_d  = 2'd0;
      wcnt_d = 4'd0;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        vec_d  = 2'd0;
        wcnt_d = 4'd0;
        done_d = 1'b0;
        pass_d = 1'b0;
        err_d  = 6'd0;
        fail_d = '0;
      end else begin
        vec_d  = vec_q;
        wcnt_d = wcnt_q;
      end
    end else if (sample_s) begin
      err_d = err_sat_s;
      for (int g = 0; g < N_GATES; g++) begin
        if (miss_s[g]) begin
          fail_d[g*4 + int'(vec_q)] = 1'b1;
        end else begin
          fail_d[g*4 + int'(vec_q)] = fail_q[g*4 + int'(vec_q)];
        end
      end
      wcnt_d = 4'd0;
      vec_d  = vec_q + 2'd1;
      if (vec_q == 2'd3) begin
        done_d = 1'b1;
        pass_d = (err_sum_s == 7'd0);
      end else begin
        done_d = done_q;
      end
    end else begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= 2'd0;
      wcnt_q <= 4'd0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 6'd0;
      fail_q <= '0;
    end else begin
      vec_q  <= vec_d;
      wcnt_q <= wcnt_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_selftest.sv
// Directed testbench for gate_selftest.
// Two instances share start/abort/expected. dut uses SETTLE=1 and dz uses
// SETTLE=0. Each instance drives its own gate models (OR, AND, XOR, NAND,
// NOT-A) with injectable stuck-at faults.
module tb_gate_selftest;

  localparam logic [19:0] EXP = 20'h3768E;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [19:0] expected;
  logic [4:0]  stuck0;
  logic [4:0]  stuck1;

  logic        a1, b1, busy1, done1, pass1;
  logic [5:0]  err1;
  logic [19:0] fail1;
  logic [4:0]  gout1;

  logic        a0, b0, busy0, done0, pass0;
  logic [5:0]  err0;
  logic [19:0] fail0;
  logic [4:0]  gout0;

  int tests_run;
  int tests_failed;

  function automatic logic [4:0] gates(input logic ia, input logic ib,
                                       input logic [4:0] s0, input logic [4:0] s1);
    logic [4:0] g;
    g[0] = ia | ib;
    g[1] = ia & ib;
    g[2] = ia ^ ib;
    g[3] = ~(ia & ib);
    g[4] = ~ia;
    return (g & ~s0) | s1;
  endfunction

  assign gout1 = gates(a1, b1, stuck0, stuck1);
  assign gout0 = gates(a0, b0, stuck0, stuck1);

  gate_selftest #(.N_GATES(5), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .gate_out(gout1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(fail1)
  );

  gate_selftest #(.N_GATES(5), .SETTLE(0)) dz (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected(expected), .gate_out(gout0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(fail0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full run on both instances. The start edge is edge 0, so after edge j
  // dut shows vector j/2 and dz shows vector j. dz is done after edge 4 and
  // dut after edge 8. When glitch is set, start is pulsed again mid-run.
  task automatic run_check(input string tag, input logic ep, input logic [5:0] ee,
                           input logic [19:0] ef, input bit glitch);
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      check({tag, " ab"}, {30'd0, a1, b1}, 32'(j / 2));
      check({tag, " busy"}, {31'd0, busy1}, 32'd1);
      check({tag, " done_early"}, {31'd0, done1}, 32'd0);
      if (j < 4) begin
        check({tag, " dz ab"}, {30'd0, a0, b0}, 32'(j));
      end else begin
        check({tag, " dz done"}, {29'd0, done0, pass0, busy0}, {29'd0, 1'b1, ep, 1'b0});
      end
      if (glitch && j == 3) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, " done"}, {31'd0, done1}, 32'd1);
    check({tag, " busy_end"}, {31'd0, busy1}, 32'd0);
    check({tag, " pass"}, {31'd0, pass1}, {31'd0, ep});
    check({tag, " err"}, {26'd0, err1}, {26'd0, ee});
    check({tag, " fail"}, {12'd0, fail1}, {12'd0, ef});
    check({tag, " dz err"}, {26'd0, err0}, {26'd0, ee});
    check({tag, " dz fail"}, {12'd0, fail0}, {12'd0, ef});
    check({tag, " ab_idle"}, {30'd0, a1, b1}, 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = EXP;
    stuck0   = 5'd0;
    stuck1   = 5'd0;
    #12;
    check("reset outs", {busy1, done1, pass1, a1, b1, err1, fail1},
          {5'd0, 6'd0, 20'd0});
    // Release between edges. The first start is taken on the next edge.
    #5 rst_n = 1'b1;
    #1;

    run_check("good", 1'b1, 6'd0, 20'd0, 1'b0);

    stuck0 = 5'b00010;
    run_check("and_sa0", 1'b0, 6'd1, 20'h00080, 1'b0);
    stuck0 = 5'd0;

    run_check("start_glitch", 1'b1, 6'd0, 20'd0, 1'b1);

    // start together with abort in IDLE: stay idle and drop done.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort busy", {31'd0, busy1}, 32'd0);
    check("start_abort done", {31'd0, done1}, 32'd0);
    tick();
    check("start_abort still idle", {31'd0, busy1}, 32'd0);

    // Abort on the cycle vector 2 is first applied (after edge 4).
    pulse_start();
    for (int j = 0; j < 4; j++) tick();
    check("abort pre ab", {30'd0, a1, b1}, 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort outs", {29'd0, busy1, done1, pass1}, 32'd0);
    check("abort ab", {30'd0, a1, b1}, 32'd0);
    run_check("after_abort", 1'b1, 6'd0, 20'd0, 1'b0);

    // Asynchronous reset while vector 1 is applied.
    pulse_start();
    tick();
    tick();
    check("mid pre ab", {30'd0, a1, b1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset outs", {busy1, done1, pass1, a1, b1, err1, fail1},
          {5'd0, 6'd0, 20'd0});
    #3 rst_n = 1'b1;
    tick();
    check("post reset idle", {31'd0, busy1}, 32'd0);
    run_check("after_reset", 1'b1, 6'd0, 20'd0, 1'b0);

    stuck1 = 5'b11111;
    run_check("all_sa1", 1'b0, 6'd9, 20'hC8971, 1'b0);
    stuck1 = 5'd0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
